// File: rtl/rv32_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter_if
// Avalon-style memory handshake bundle used on every side of the memory
// arbiter (instruction port, data port and the shared memory port).
//   address    32  byte address
//   read       1   read request
//   write      1   write request (never together with read)
//   writedata  32  write data
//   byteenable 4   write byte enables
//   readdata   32  read data, valid in the cycle waitrequest is low
//   waitrequest 1  stall; the access completes in the cycle it is low
// master: the requester (drives the command); slave: the responder.
// ---------------------------------------------------------------------------
interface rv32_mem_arbiter_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address, read, write, writedata, byteenable,
      input  readdata, waitrequest
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output readdata, waitrequest
   );
endinterface

// File: rtl/rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares one single-ported memory between the core's instruction fetch port
// and its data port. Data normally wins (the core stalls on data waits); a
// fairness counter (dcnt) lets a pending fetch through after D_MAX_CONSEC
// consecutive data completions. When the memory stalls, the grant is locked
// until the access completes or the requester withdraws.
//
// Ports
//   clk, reset  system clock; asynchronous active-high reset
//   i_bus       slave  : instruction side (address/read used, readdata out)
//   d_bus       slave  : data side (read/write/writedata/byteenable)
//   m_bus       master : shared memory port
// Optional (macro RV32_ARB_STATS_EN defined):
//   stat_clr           synchronous clear of all statistics counters
//   stat_i_cnt         instruction completions
//   stat_d_cnt         data completions
//   stat_conflict_cnt  cycles with both sides requesting
//
// Parameter
//   D_MAX_CONSEC  consecutive data completions allowed while a fetch is
//                 pending (0 = strict data priority), range 0..15
// ---------------------------------------------------------------------------
module rv32_mem_arbiter #(
   parameter int unsigned D_MAX_CONSEC = 4
) (
   input  logic               clk,
   input  logic               reset,
   rv32_mem_arbiter_if.slave  i_bus,
   rv32_mem_arbiter_if.slave  d_bus,
   rv32_mem_arbiter_if.master m_bus
`ifdef RV32_ARB_STATS_EN
   ,
   input  logic               stat_clr,
   output logic [31:0]        stat_i_cnt,
   output logic [31:0]        stat_d_cnt,
   output logic [31:0]        stat_conflict_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

   localparam logic [3:0] D_MAX = 4'(D_MAX_CONSEC);

   state_e     state_q, state_d;
   logic [3:0] dcnt_q, dcnt_d;
   logic       d_req, starve;
   logic       grant_i, grant_d;
   logic       i_done, d_done;

   assign d_req  = d_bus.read | d_bus.write;
   assign starve = (D_MAX != 4'd0) && (dcnt_q == D_MAX);

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned, which would infer a latch.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      state_d = state_q;
      dcnt_d  = dcnt_q;

      case (state_q)
         LOCK_I:  grant_i = 1'b1;
         LOCK_D:  grant_d = 1'b1;
         default: begin
            grant_i = i_bus.read & (~d_req | starve);
            grant_d = ~grant_i & d_req;
         end
      endcase

      // Reset abandons any access: no grant, so no command and no completion.
      if (reset) begin
         grant_i = 1'b0;
         grant_d = 1'b0;
      end

      // A locked side that withdrew its request cannot complete.
      i_done = grant_i & i_bus.read & ~m_bus.waitrequest;
      d_done = grant_d & d_req & ~m_bus.waitrequest;

      // Stay locked only while the owner still requests and memory stalls.
      if (grant_i && i_bus.read && m_bus.waitrequest)
         state_d = LOCK_I;
      else if (grant_d && d_req && m_bus.waitrequest)
         state_d = LOCK_D;
      else
         state_d = IDLE;

      if (i_done)
         dcnt_d = 4'd0;
      else if (d_done && i_bus.read && (dcnt_q < D_MAX))
         dcnt_d = dcnt_q + 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from values sampled at the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         dcnt_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
      end
   end

   assign m_bus.read       = (grant_i & i_bus.read) | (grant_d & d_bus.read);
   assign m_bus.write      = grant_d & d_bus.write;
   assign m_bus.address    = grant_i ? i_bus.address :
                             grant_d ? d_bus.address : 32'd0;
   assign m_bus.writedata  = d_bus.writedata;
   assign m_bus.byteenable = (grant_d & d_bus.write) ? d_bus.byteenable : 4'hf;

   assign i_bus.readdata    = m_bus.readdata;
   assign d_bus.readdata    = m_bus.readdata;
   assign i_bus.waitrequest = ~i_done;
   assign d_bus.waitrequest = ~d_done;

`ifdef RV32_ARB_STATS_EN
   logic [31:0] stat_i_q, stat_i_d;
   logic [31:0] stat_d_q, stat_d_d;
   logic [31:0] stat_c_q, stat_c_d;

   // Clear takes precedence over a same-cycle increment.
   always_comb begin
      stat_i_d = stat_i_q + {31'd0, i_done};
      stat_d_d = stat_d_q + {31'd0, d_done};
      stat_c_d = stat_c_q + {31'd0, i_bus.read & d_req};
      if (stat_clr) begin
         stat_i_d = 32'd0;
         stat_d_d = 32'd0;
         stat_c_d = 32'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_i_q <= 32'd0;
         stat_d_q <= 32'd0;
         stat_c_q <= 32'd0;
      end else begin
         stat_i_q <= stat_i_d;
         stat_d_q <= stat_d_d;
         stat_c_q <= stat_c_d;
      end
   end

   assign stat_i_cnt        = stat_i_q;
   assign stat_d_cnt        = stat_d_q;
   assign stat_conflict_cnt = stat_c_q;
`endif

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32_mem_arbiter
// Directed scenarios followed by random traffic. Expected outputs come from a
// behavioural model that tracks who owns the memory port and how many data
// accesses have completed in a row while a fetch was waiting.
// Inputs change on the falling edge; outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_rv32_mem_arbiter;
   localparam int unsigned D_MAX = 4;
   localparam int NONE = 0, INS = 1, DAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rv32_mem_arbiter_if i_if ();
   rv32_mem_arbiter_if d_if ();
   rv32_mem_arbiter_if m_if ();

`ifdef RV32_ARB_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_i_cnt, stat_d_cnt, stat_conflict_cnt;
   int          mdl_si, mdl_sd, mdl_sc;
`endif

   rv32_mem_arbiter #(.D_MAX_CONSEC(D_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .i_bus (i_if),
      .d_bus (d_if),
      .m_bus (m_if)
`ifdef RV32_ARB_STATS_EN
      ,
      .stat_clr          (stat_clr),
      .stat_i_cnt        (stat_i_cnt),
      .stat_d_cnt        (stat_d_cnt),
      .stat_conflict_cnt (stat_conflict_cnt)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   // Model state: owner of a stalled access, and the data-streak length.
   int held   = NONE;
   int consec = 0;
   int who    = NONE;
   int obs_i_done_cnt = 0;
   int obs_d_done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Who gets the port this cycle, from the arbitration rules.
   function automatic int owner(input logic ir, input logic dr, input logic dw, input logic rst);
      if (rst) return NONE;
      if (held != NONE) return held;
      if (ir && (!(dr || dw) || (D_MAX != 0 && consec == D_MAX))) return INS;
      if (dr || dw) return DAT;
      return NONE;
   endfunction

   task automatic run_cycle(input logic ir, input logic [31:0] ia,
                            input logic dr, input logic dw, input logic [31:0] da,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic mw, input logic rst);
      logic [31:0] rd;
      logic        exp_rd, exp_wr, exp_iw, exp_dw;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic        completes;
      @(negedge clk);
      rd = $urandom;
      i_if.address = ia; i_if.read = ir;
      d_if.address = da; d_if.read = dr; d_if.write = dw;
      d_if.writedata = wd; d_if.byteenable = be;
      m_if.waitrequest = mw; m_if.readdata = rd;
      reset = rst;
      #1;
      who      = owner(ir, dr, dw, rst);
      exp_rd   = (who == INS && ir) || (who == DAT && dr);
      exp_wr   = (who == DAT && dw);
      exp_addr = (who == INS) ? ia : (who == DAT) ? da : 32'd0;
      exp_be   = (who == DAT && dw) ? be : 4'hf;
      exp_iw   = !(who == INS && ir && !mw);
      exp_dw   = !(who == DAT && (dr || dw) && !mw);
      check("m_read", m_if.read, exp_rd);
      check("m_write", m_if.write, exp_wr);
      check("m_address", m_if.address, exp_addr);
      check("m_byteenable", m_if.byteenable, exp_be);
      check("m_writedata", m_if.writedata, wd);
      check("i_waitrequest", i_if.waitrequest, exp_iw);
      check("d_waitrequest", d_if.waitrequest, exp_dw);
      check("i_readdata", i_if.readdata, rd);
      check("d_readdata", d_if.readdata, rd);
      if (!i_if.waitrequest) obs_i_done_cnt++;
      if (!d_if.waitrequest) obs_d_done_cnt++;
      @(posedge clk);
      // Advance the model with the inputs that were sampled at this edge.
      completes = 1'b0;
      if (rst) begin
         held = NONE; consec = 0;
      end else if (who == INS) begin
         held = (ir && mw) ? INS : NONE;
         completes = ir && !mw;
         if (completes) consec = 0;
      end else if (who == DAT) begin
         held = ((dr || dw) && mw) ? DAT : NONE;
         completes = (dr || dw) && !mw;
         if (completes && ir && consec < int'(D_MAX)) consec++;
      end else begin
         held = NONE;
      end
`ifdef RV32_ARB_STATS_EN
      if (rst || stat_clr) begin
         mdl_si = 0; mdl_sd = 0; mdl_sc = 0;
      end else begin
         if (completes && who == INS) mdl_si++;
         if (completes && who == DAT) mdl_sd++;
         if (ir && (dr || dw)) mdl_sc++;
      end
`endif
   endtask

   task automatic idle_cycle(input logic rst);
      run_cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b0, rst);
   endtask

   initial begin
      i_if.address = '0; i_if.read = 1'b0; i_if.write = 1'b0;
      i_if.writedata = '0; i_if.byteenable = 4'hf;
      d_if.address = '0; d_if.read = 1'b0; d_if.write = 1'b0;
      d_if.writedata = '0; d_if.byteenable = '0;
      m_if.waitrequest = 1'b0; m_if.readdata = '0;
      reset = 1'b1;
`ifdef RV32_ARB_STATS_EN
      stat_clr = 1'b0;
      mdl_si = 0; mdl_sd = 0; mdl_sc = 0;
`endif

      // Reset state, including requests present while reset is held.
      idle_cycle(1'b1);
      run_cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 1'b1);
      idle_cycle(1'b0);

      // Single fetch, no wait: completes in the same cycle.
      run_cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      check("t1_addr", m_if.address, 32'h100);

      // Fetch and store together: store wins, fetch follows.
      run_cycle(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 32'hdeadbeef, 4'h3, 1'b0, 1'b0);
      check("t2_be", m_if.byteenable, 32'h3);
      run_cycle(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

      // Fairness: three rounds of four loads and one fetch.
      obs_i_done_cnt = 0; obs_d_done_cnt = 0;
      for (int k = 0; k < 15; k++)
         run_cycle(1'b1, 32'h108, 1'b1, 1'b0, 32'h400 + 32'(k * 4), 32'h0, 4'h0, 1'b0, 1'b0);
      check("t3_fetches", obs_i_done_cnt, 32'd3);
      check("t3_loads", obs_d_done_cnt, 32'd12);

      // Load stalled three cycles, completes on the fourth, fetch on the fifth.
      for (int k = 0; k < 3; k++)
         run_cycle(1'b1, 32'h10c, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h10c, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0);
      run_cycle(1'b1, 32'h10c, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      check("t4_fetch_addr", m_if.address, 32'h10c);

      // Build a data streak, lock a fetch, then reset mid-access.
      run_cycle(1'b1, 32'h110, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0, 1'b0, 1'b0);
      run_cycle(1'b1, 32'h110, 1'b1, 1'b0, 32'h504, 32'h0, 4'h0, 1'b0, 1'b0);
      run_cycle(1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h110, 1'b1, 1'b0, 32'h508, 32'h0, 4'h0, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h110, 1'b1, 1'b0, 32'h508, 32'h0, 4'h0, 1'b0, 1'b1);
      check("t5_rst_read", m_if.read, 32'd0);
      check("t5_rst_iwait", i_if.waitrequest, 32'd1);
      idle_cycle(1'b1);
      obs_i_done_cnt = 0;
      for (int k = 0; k < 5; k++)
         run_cycle(1'b1, 32'h114, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 1'b0, 1'b0);
      check("t5_streak_fetch", obs_i_done_cnt, 32'd1);

      // Store stalled, then cancelled while locked; fetch gets the port next.
      run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h700, 32'h1234, 4'hc, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h118, 1'b0, 1'b0, 32'h700, 32'h1234, 4'hc, 1'b1, 1'b0);
      run_cycle(1'b1, 32'h118, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         logic ir, dr, dw, mw, rs;
         int   op;
         ir = ($urandom_range(0, 3) != 0);
         op = $urandom_range(0, 3);
         dr = (op == 1) || (op == 2);
         dw = (op == 3);
         mw = ($urandom_range(0, 2) == 0);
         rs = ($urandom_range(0, 63) == 0);
         run_cycle(ir, {$urandom_range(0, 255), 2'b00} << 2, dr, dw,
                   32'($urandom), 32'($urandom), 4'($urandom), mw, rs);
      end

`ifdef RV32_ARB_STATS_EN
      idle_cycle(1'b1);
      for (int k = 0; k < 10; k++) begin
         logic st;
         st = (k < 3);
         run_cycle(1'b1, 32'h800 + 32'(k * 4), 1'b0, st, 32'h900, 32'(k), 4'hf, 1'b0, 1'b0);
         if (st)
            run_cycle(1'b1, 32'h800 + 32'(k * 4), 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      end
      idle_cycle(1'b0);
      check("stat_i", stat_i_cnt, 32'd10);
      check("stat_d", stat_d_cnt, 32'd3);
      check("stat_c", stat_conflict_cnt, 32'(mdl_sc));
      stat_clr = 1'b1;
      run_cycle(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
      stat_clr = 1'b0;
      check("stat_clr_i", stat_i_cnt, 32'(mdl_si));
      check("stat_clr_d", stat_d_cnt, 32'd0);
      check("stat_clr_c", stat_conflict_cnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
